// File: rtl/tedv3_main_memory_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tedv3_main_memory_master
// Purpose  : Command-driven block mover between a single-port 32-bit memory
//            and a read/write stream pair, with a 2-entry read-return FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tedv3_main_memory_master #(
    parameter int DEPTH = 65000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    output logic [15:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_read  = 2'd1;
    localparam logic [1:0]  c_st_write = 2'd2;
    localparam logic [1:0]  c_st_done  = 2'd3;
    localparam logic [16:0] c_depth    = 17'(DEPTH);

    logic [1:0]  r_state;
    logic [15:0] r_ptr;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [15:0] r_popped;
    logic        r_err;
    logic        r_inflight;
    logic [31:0] r_fifo [0:1];
    logic        r_fifo_wr;
    logic        r_fifo_rd;
    logic [1:0]  r_fifo_count;

    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_rd_issue;
    logic        w_wr_beat;
    logic [16:0] w_cmd_end;

    assign rd_valid  = (r_fifo_count != 2'd0);
    assign rd_data   = r_fifo[r_fifo_rd];
    assign w_pop     = rd_valid & rd_ready;

    // Occupancy seen by the next read: what is buffered plus what is still
    // returning, less the word leaving this cycle, so the FIFO cannot overflow.
    assign w_occ      = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_issue = (r_state == c_st_read) && (r_cnt < r_len) && (w_occ < 3'd2);
    assign w_wr_beat  = (r_state == c_st_write) && wr_valid;
    assign w_cmd_end  = {1'b0, cmd_addr} + {1'b0, cmd_len};

    assign mem_chipselect = w_rd_issue | w_wr_beat;
    assign mem_write      = w_wr_beat;
    assign mem_address    = r_ptr;
    assign mem_writedata  = wr_data;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign cmd_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign err       = (r_state == c_st_done) & r_err;
    assign wr_ready  = (r_state == c_st_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_ptr        <= 16'd0;
            r_len        <= 16'd0;
            r_cnt        <= 16'd0;
            r_popped     <= 16'd0;
            r_err        <= 1'b0;
            r_inflight   <= 1'b0;
            r_fifo[0]    <= 32'd0;
            r_fifo[1]    <= 32'd0;
            r_fifo_wr    <= 1'b0;
            r_fifo_rd    <= 1'b0;
            r_fifo_count <= 2'd0;
        end else begin
            r_inflight <= w_rd_issue;

            // Memory returns data one cycle after the access; capture it then.
            if (r_inflight) begin
                r_fifo[r_fifo_wr] <= mem_readdata;
                r_fifo_wr         <= ~r_fifo_wr;
            end
            if (w_pop) begin
                r_fifo_rd <= ~r_fifo_rd;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase

            case (r_state)
                c_st_idle: begin
                    r_err <= 1'b0;
                    if (cmd_valid) begin
                        r_ptr    <= cmd_addr;
                        r_len    <= cmd_len;
                        r_cnt    <= 16'd0;
                        r_popped <= 16'd0;
                        if (cmd_len == 16'd0) begin
                            r_state <= c_st_done;
                        end else if (w_cmd_end > c_depth) begin
                            r_err   <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_state <= cmd_write ? c_st_write : c_st_read;
                        end
                    end
                end
                c_st_read: begin
                    if (w_rd_issue) begin
                        r_ptr <= r_ptr + 16'd1;
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (w_pop) begin
                        r_popped <= r_popped + 16'd1;
                        if (r_popped == r_len - 16'd1) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_write: begin
                    if (w_wr_beat) begin
                        r_ptr <= r_ptr + 16'd1;
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == r_len - 16'd1) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tedv3_main_memory_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_tedv3_main_memory_master
// Purpose  : Directed self-checking bench with a behavioural 1-cycle memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_tedv3_main_memory_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp;
    int n_err;

    logic [31:0] mem [0:65535];

    tedv3_main_memory_master dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
    end

    function automatic logic [31:0] word_a(input int i);
        return 32'hCAFE_00A0 + 32'(i);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        n_cmp++; if ({mem_chipselect, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_cs_we: got %b expected 00", {mem_chipselect, mem_write}); end
        n_cmp++; if (mem_address !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", mem_address); end
        n_cmp++; if ({done, err} !== 2'b00) begin n_err++; $display("FAIL reset_done_err: got %b expected 00", {done, err}); end
        n_cmp++; if ({mem_byteenable, mem_clken} !== 5'b11111) begin n_err++; $display("FAIL const_be_clken: got %b expected 11111", {mem_byteenable, mem_clken}); end
        reset = 1'b0;
    endtask

    task automatic test_write;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010; cmd_len = 16'd4;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_cmd_ready: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = word_a(i);
            #1;
            n_cmp++; if ({wr_ready, mem_chipselect, mem_write} !== 3'b111) begin n_err++; $display("FAIL wr_beat%0d_ctl: got %b expected 111", i, {wr_ready, mem_chipselect, mem_write}); end
            n_cmp++; if (mem_address !== 16'h0010 + 16'(i)) begin n_err++; $display("FAIL wr_beat%0d_addr: got %h expected %h", i, mem_address, 16'h0010 + 16'(i)); end
            n_cmp++; if (mem_writedata !== word_a(i)) begin n_err++; $display("FAIL wr_beat%0d_data: got %h expected %h", i, mem_writedata, word_a(i)); end
            tick();
        end
        wr_valid = 1'b0;
        #1;
        n_cmp++; if ({done, err, mem_chipselect, wr_ready} !== 4'b1000) begin n_err++; $display("FAIL wr_done: got %b expected 1000", {done, err, mem_chipselect, wr_ready}); end
        tick();
        n_cmp++; if ({done, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL wr_idle: got %b expected 01", {done, cmd_ready}); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[16'h0010 + 16'(i)] !== word_a(i)) begin n_err++; $display("FAIL wr_mem%0d: got %h expected %h", i, mem[16'h0010 + 16'(i)], word_a(i)); end
        end
    endtask

    task automatic test_read;
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 16'd4;
        tick();
        cmd_valid = 1'b0;
        #1;
        n_cmp++; if ({mem_chipselect, mem_write, rd_valid} !== 3'b100 || mem_address !== 16'h0010) begin n_err++; $display("FAIL rd_first_issue: got cs/we/v=%b addr=%h expected 100 addr=0010", {mem_chipselect, mem_write, rd_valid}, mem_address); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 16'h0011) begin n_err++; $display("FAIL rd_second_issue: got v=%b cs=%b addr=%h expected v=0 cs=1 addr=0011", rd_valid, mem_chipselect, mem_address); end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== word_a(i)) begin n_err++; $display("FAIL rd_word%0d: got v=%b data=%h expected v=1 data=%h", i, rd_valid, rd_data, word_a(i)); end
            if (i == 2) begin
                n_cmp++; if (mem_chipselect !== 1'b0) begin n_err++; $display("FAIL rd_no_extra_issue: got %b expected 0", mem_chipselect); end
            end
            tick();
        end
        n_cmp++; if ({done, err, rd_valid} !== 3'b100) begin n_err++; $display("FAIL rd_done: got %b expected 100", {done, err, rd_valid}); end
        tick();
        n_cmp++; if ({done, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rd_idle: got %b expected 01", {done, cmd_ready}); end
    endtask

    task automatic test_read_toggle;
        logic [3:0]  pat;
        logic [31:0] got [0:7];
        int issued;
        int popped;
        int over;
        bit seen_done;
        pat = 4'b1001;
        issued = 0; popped = 0; over = 0; seen_done = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 16'd4;
        rd_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            rd_ready = pat[3 - (k % 4)];
            #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (issued - popped > 2) over++;
            if (mem_chipselect && !mem_write) issued++;
            if (rd_valid && rd_ready) begin
                if (popped < 8) got[popped] = rd_data;
                popped++;
            end
            tick();
        end
        n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL tog_done: got %b expected 1 within budget", seen_done); end
        n_cmp++; if (popped != 4) begin n_err++; $display("FAIL tog_pops: got %0d expected 4", popped); end
        n_cmp++; if (over != 0) begin n_err++; $display("FAIL tog_occupancy: got %0d cycles above 2 expected 0", over); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got[i] !== word_a(i)) begin n_err++; $display("FAIL tog_word%0d: got %h expected %h", i, got[i], word_a(i)); end
        end
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic test_bounds;
        int beats;
        logic [15:0] last;
        bit seen_done;
        beats = 0; last = 16'h0; seen_done = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'd64990; cmd_len = 16'd11;
        #1;
        n_cmp++; if (mem_chipselect !== 1'b0) begin n_err++; $display("FAIL oob_idle_cs: got %b expected 0", mem_chipselect); end
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        #1;
        n_cmp++; if ({done, err, mem_chipselect} !== 3'b110) begin n_err++; $display("FAIL oob_done_err: got %b expected 110", {done, err, mem_chipselect}); end
        wr_valid = 1'b0;
        tick();
        n_cmp++; if ({done, err, cmd_ready} !== 3'b001) begin n_err++; $display("FAIL oob_idle: got %b expected 001", {done, err, cmd_ready}); end

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'd64990; cmd_len = 16'd10;
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 32'(k);
            #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (mem_chipselect && mem_write) begin
                beats++;
                last = mem_address;
            end
            tick();
        end
        n_cmp++; if (seen_done !== 1'b1 || err !== 1'b0 || mem_chipselect !== 1'b0) begin n_err++; $display("FAIL edge_done: got done=%b err=%b cs=%b expected 1 0 0", seen_done, err, mem_chipselect); end
        n_cmp++; if (beats != 10) begin n_err++; $display("FAIL edge_beats: got %0d expected 10", beats); end
        n_cmp++; if (last !== 16'd64999) begin n_err++; $display("FAIL edge_last_addr: got %0d expected 64999", last); end
        wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 16'd0;
        tick();
        n_cmp++; if ({done, err, cmd_ready, mem_chipselect} !== 4'b1000) begin n_err++; $display("FAIL len0_done: got %b expected 1000", {done, err, cmd_ready, mem_chipselect}); end
        tick();
        n_cmp++; if ({done, cmd_ready, mem_chipselect} !== 3'b010) begin n_err++; $display("FAIL len0_idle: got %b expected 010", {done, cmd_ready, mem_chipselect}); end
        tick();
        n_cmp++; if ({done, err} !== 2'b10) begin n_err++; $display("FAIL len0_again: got %b expected 10", {done, err}); end
        cmd_valid = 1'b0;
        tick();
        n_cmp++; if ({done, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL len0_end: got %b expected 01", {done, cmd_ready}); end
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] got [0:7];
        int pops;
        int done_seen;
        bit seen_done;
        pops = 0; done_seen = 0; seen_done = 1'b0;
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 16'd8;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rd_valid && rd_ready) begin
                got[pops] = rd_data;
                pops++;
            end
            tick();
            if (pops == 3) break;
        end
        n_cmp++; if (pops != 3) begin n_err++; $display("FAIL mid_pops: got %0d expected 3", pops); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got[i] !== word_a(i)) begin n_err++; $display("FAIL mid_word%0d: got %h expected %h", i, got[i], word_a(i)); end
        end
        reset    = 1'b1;
        rd_ready = 1'b0;
        tick();
        n_cmp++; if ({cmd_ready, rd_valid, busy, done, mem_chipselect} !== 5'b10000) begin n_err++; $display("FAIL mid_reset: got %b expected 10000", {cmd_ready, rd_valid, busy, done, mem_chipselect}); end
        reset    = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (done) done_seen++;
            tick();
        end
        n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_seen); end

        pops = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0010; cmd_len = 16'd2;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (rd_valid && rd_ready) begin
                if (pops < 8) got[pops] = rd_data;
                pops++;
            end
            tick();
        end
        n_cmp++; if (seen_done !== 1'b1 || pops != 2) begin n_err++; $display("FAIL post_reset_read: got done=%b pops=%0d expected done=1 pops=2", seen_done, pops); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (got[i] !== word_a(i)) begin n_err++; $display("FAIL post_word%0d: got %h expected %h", i, got[i], word_a(i)); end
        end
        tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 16'h0;
        rd_ready = 1'b0; wr_data = 32'h0; wr_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_read_toggle();
        test_bounds();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tedv3_main_memory_master.md
TEDV3_MAIN_MEMORY_MASTER -- requirements
Module: tedv3_main_memory_master

Interface
REQ-001 Parameter: DEPTH, default 65000, number of 32-bit words in the target memory.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_write  input  1  1 = stream-to-memory write, 0 = memory-to-stream read.
REQ-007 cmd_addr  input  16  first word address.
REQ-008 cmd_len  input  16  word count.
REQ-009 mem_address  output  16  memory word address.
REQ-010 mem_byteenable  output  4  byte enables, constant 4'hF.
REQ-011 mem_chipselect  output  1  memory access this cycle.
REQ-012 mem_write  output  1  write access, only ever with mem_chipselect.
REQ-013 mem_writedata  output  32  write data.
REQ-014 mem_clken  output  1  memory clock enable, constant 1.
REQ-015 mem_readdata  input  32  read data, valid exactly 1 cycle after a read access.
REQ-016 rd_data / rd_valid / rd_ready  output 32 / output 1 / input 1  read stream; beat on rd_valid & rd_ready.
REQ-017 wr_data / wr_valid / wr_ready  input 32 / input 1 / output 1  write stream; beat on wr_valid & wr_ready.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle completion pulse.
REQ-020 err  output  1  one-cycle pulse, coincident with done, on a rejected command.

Function
REQ-021 States: IDLE, READ, WRITE, DONE; cmd_ready = (state == IDLE).
REQ-022 On acceptance: latch addr, len and direction.
- len == 0: go to DONE, no memory access.
- addr + len > DEPTH (17-bit compare): go to DONE with err, no memory access.
- Otherwise go to READ or WRITE.
REQ-023 DONE lasts exactly 1 cycle with done = 1, err per REQ-022, then IDLE.
REQ-024 READ: a read issues (chipselect = 1, write = 0, address = current pointer) iff words issued < len and fifo_count + inflight − (rd_valid & rd_ready) < 2.
REQ-025 Each issued read increments the pointer by 1; inflight = 1 during the cycle after issue.
REQ-026 Read data goes into a 2-entry FIFO at the edge ending the cycle after issue; rd_data = FIFO head, rd_valid = FIFO non-empty.
- First rd_valid is 2 cycles after the first issue.
- Sustained throughput is 1 word/cycle while rd_ready = 1.
REQ-027 READ → DONE in the cycle after the last (len-th) word is popped.
- The FIFO never overflows under any rd_ready pattern.
- Data order equals address order.
REQ-028 WRITE: wr_ready = 1.
- mem_chipselect = mem_write = wr_valid.
- mem_writedata = wr_data; mem_address = pointer.
- Pointer and count advance on each beat.
REQ-029 WRITE → DONE on the cycle after the len-th beat; wr_ready = 0 outside WRITE.
REQ-030 mem_chipselect = 0 in IDLE and DONE, and in READ/WRITE when no access occurs.
REQ-031 cmd_valid while busy is ignored (no queueing).

Reset
REQ-032 While reset = 1 at an edge, the following take effect on the next cycle:
- state = IDLE, FIFO emptied, inflight cleared, counters and pointer = 0.
- Outputs: cmd_ready = 1, rd_valid = 0, wr_ready = 0, mem_chipselect = 0, mem_write = 0, mem_address = 0, busy = 0, done = 0, err = 0.
REQ-033 Reset mid-transfer aborts the transfer: a read in flight is discarded, and no done pulse is produced.

Verification
REQ-034 Write addr = 0x0010, len = 4, wr_valid held high with data A0..A3 -> 4 consecutive writes to 0x10..0x13, done 1 cycle after the 4th beat.
REQ-035 Read addr = 0x0010, len = 4, rd_ready = 1 -> first rd_valid 2 cycles after the first access; A0..A3 on consecutive cycles; done 1 cycle after the last pop.
REQ-036 Same read with rd_ready toggling 1,0,0,1,... -> no lost or duplicated words, FIFO never exceeds 2, order A0..A3.
REQ-037 addr = 64990, len = 11 -> done & err pulse, mem_chipselect never asserted; addr = 64990, len = 10 -> accepted, last address 64999.
REQ-038 len = 0 -> done pulse 1 cycle after acceptance, err = 0, no access.
REQ-039 Reset asserted mid-read of len = 8 after 3 pops -> IDLE with cmd_ready = 1 and rd_valid = 0 next cycle, no done pulse; a following command runs normally.
